// File: rtl/data_bus_confreg_if.sv
// data_bus_confreg_if: SRAM-style data bus (one request per cycle, 1-cycle
// read latency). Used for both the core-facing and the RAM-facing side.
//   en     request valid
//   we     byte write enables, 0 = read
//   addr   byte address
//   wdata  write data
//   rdata  read data, valid the cycle after a read
// master: issues requests (core, or this block towards RAM).
// slave : serves requests.
interface data_bus_confreg_if;
  logic        en;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output en, we, addr, wdata, input rdata);
  modport slave  (input en, we, addr, wdata, output rdata);
endinterface

// File: rtl/data_bus_confreg.sv
// data_bus_confreg: address decoder between the core data port and data RAM.
// Accesses hitting the config window are served by a local register file
// (LED, switch, timer/compare interrupt, UART TX FIFO); all other accesses
// pass straight through to RAM.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   cpu (slave)     core data port: en/we/addr/wdata in, rdata out
//   ram (master)    data RAM port: en/we/addr/wdata out, rdata in
//   switch          board switches (asynchronous, synchronized here)
//   led             LED register
//   uart_tx_*       FIFO head valid/data, consumer ready
//   ext_int         timer interrupt level (PEND & EN)
module data_bus_confreg #(
  parameter logic [31:0] CONF_BASE  = 32'hBFAF_0000,
  parameter logic [31:0] CONF_MASK  = 32'hFFFF_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  data_bus_confreg_if.slave         cpu,
  data_bus_confreg_if.master        ram,
  input  logic [7:0]                switch,
  output logic [15:0]               led,
  output logic                      uart_tx_valid,
  output logic [7:0]                uart_tx_data,
  input  logic                      uart_tx_ready,
  output logic                      ext_int
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [5:0] W_LED   = 6'h00;
  localparam logic [5:0] W_SW    = 6'h01;
  localparam logic [5:0] W_TIMER = 6'h02;
  localparam logic [5:0] W_CMP   = 6'h03;
  localparam logic [5:0] W_INT   = 6'h04;
  localparam logic [5:0] W_UART  = 6'h05;

  logic          hit, conf_wr, conf_rd;
  logic [5:0]    word;

  logic          sel_conf_q, sel_conf_d;
  logic [31:0]   conf_rdata_q, conf_rdata_d;
  logic [7:0]    sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
  logic [15:0]   led_q, led_d;
  logic [31:0]   timer_q, timer_d, cmp_q, cmp_d;
  logic          int_en_q, int_en_d, pend_q, pend_d;
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [7:0]    fifo_d [FIFO_DEPTH];
  logic [PW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          fifo_full, fifo_empty, push, push_ok, pop;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  // Decode and pass-through
  always_comb begin
    hit       = cpu.en && ((cpu.addr & CONF_MASK) == CONF_BASE);
    conf_wr   = hit && (cpu.we != '0);
    conf_rd   = hit && (cpu.we == '0);
    word      = cpu.addr[7:2];
    ram.en    = cpu.en && !hit;
    ram.we    = ram.en ? cpu.we : '0;
    ram.addr  = cpu.addr;
    ram.wdata = cpu.wdata;
    // sel_conf resets to 1 with conf_rdata 0 so the undefined RAM path is
    // masked while in reset.
    cpu.rdata = sel_conf_q ? conf_rdata_q : ram.rdata;
  end

  always_comb begin
    fifo_full     = (count_q == CW'(FIFO_DEPTH));
    fifo_empty    = (count_q == '0);
    uart_tx_valid = !fifo_empty;
    uart_tx_data  = fifo_q[rptr_q];
    led           = led_q;
    ext_int       = pend_q & int_en_q;
  end

  // Next-state logic
  always_comb begin
    sel_conf_d   = hit;
    conf_rdata_d = conf_rdata_q;
    sw_meta_d    = switch;
    sw_sync_d    = sw_meta_q;
    led_d        = led_q;
    timer_d      = timer_q + 32'd1;
    cmp_d        = cmp_q;
    int_en_d     = int_en_q;
    pend_d       = pend_q;
    fifo_d       = fifo_q;
    rptr_d       = rptr_q;
    wptr_d       = wptr_q;
    ovf_d        = ovf_q;
    push         = 1'b0;

    if (conf_wr) begin
      unique case (word)
        W_LED: begin
          if (cpu.we[0]) led_d[7:0]  = cpu.wdata[7:0];
          if (cpu.we[1]) led_d[15:8] = cpu.wdata[15:8];
        end
        W_TIMER: timer_d = merge_bytes(timer_q, cpu.wdata, cpu.we);
        W_CMP:   cmp_d   = merge_bytes(cmp_q, cpu.wdata, cpu.we);
        W_INT: begin
          if (cpu.we[0]) begin
            int_en_d = cpu.wdata[0];
            if (cpu.wdata[1]) pend_d = 1'b0;
          end
        end
        W_UART:  push = cpu.we[0];
        default: ;
      endcase
    end

    // Compare uses the pre-increment timer; a set overrides a same-cycle W1C.
    if (timer_q == cmp_q) pend_d = 1'b1;

    if (conf_rd) begin
      unique case (word)
        W_LED:   conf_rdata_d = {16'b0, led_q};
        W_SW:    conf_rdata_d = {24'b0, sw_sync_q};
        W_TIMER: conf_rdata_d = timer_q;
        W_CMP:   conf_rdata_d = cmp_q;
        W_INT:   conf_rdata_d = {30'b0, pend_q, int_en_q};
        W_UART: begin
          conf_rdata_d = 32'({ovf_q, fifo_full, fifo_empty, count_q});
          ovf_d        = 1'b0;
        end
        default: conf_rdata_d = '0;
      endcase
    end

    // A push into a full FIFO still lands if the head leaves this cycle.
    pop     = uart_tx_valid && uart_tx_ready;
    push_ok = push && (!fifo_full || pop);
    if (push && !push_ok) ovf_d = 1'b1;
    if (push_ok) begin
      fifo_d[wptr_q] = cpu.wdata[7:0];
      wptr_d         = wptr_q + PW'(1);
    end
    if (pop) rptr_d = rptr_q + PW'(1);
    count_d = count_q + CW'(push_ok) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_conf_q   <= 1'b1;
      conf_rdata_q <= '0;
      sw_meta_q    <= '0;
      sw_sync_q    <= '0;
      led_q        <= '0;
      timer_q      <= '0;
      cmp_q        <= '1;
      int_en_q     <= 1'b0;
      pend_q       <= 1'b0;
      fifo_q       <= '{default: '0};
      rptr_q       <= '0;
      wptr_q       <= '0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
    end else begin
      sel_conf_q   <= sel_conf_d;
      conf_rdata_q <= conf_rdata_d;
      sw_meta_q    <= sw_meta_d;
      sw_sync_q    <= sw_sync_d;
      led_q        <= led_d;
      timer_q      <= timer_d;
      cmp_q        <= cmp_d;
      int_en_q     <= int_en_d;
      pend_q       <= pend_d;
      fifo_q       <= fifo_d;
      rptr_q       <= rptr_d;
      wptr_q       <= wptr_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
    end
  end

endmodule
